// File: rtl/dpll_frame_stack.sv
// ============================================================================
// Module   : dpll_frame_stack
// Brief    : DPLL backtracking stack, one frame (formula/assignment + branch
//            bit) per decision level. Optional DPLL_STACK_HWM_EN adds a
//            high-water-mark output (max_depth_o).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpll_frame_stack #(
  parameter int NUM_CLAUSES = 10,
  parameter int NUM_LITS    = 5,
  parameter int DEPTH       = NUM_LITS,
  localparam int LW         = $clog2(NUM_LITS + 1),
  localparam int CW         = $clog2(NUM_CLAUSES + 1),
  localparam int FRAME_W    = NUM_CLAUSES * (NUM_LITS * (LW + 1) + LW) + CW + 2 * NUM_LITS,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               cmd_valid_i,
  input  logic [1:0]         cmd_op_i,
  output logic               cmd_ready_o,
  input  logic [FRAME_W-1:0] push_frame_i,
  output logic               top_valid_o,
  output logic [FRAME_W-1:0] top_frame_o,
  output logic               top_branch_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               full_o,
  output logic               empty_o,
  input  logic               clr_err_i,
  output logic               err_overflow_o,
  output logic               err_underflow_o,
  output logic               err_flip_o
`ifdef DPLL_STACK_HWM_EN
  ,
  output logic [CNT_W-1:0]   max_depth_o
`endif
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_REFILL = 1'b1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_FLIP = 2'b11;

  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]   br_q, br_d;
  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [FRAME_W-1:0] top_frame_q, top_frame_d;
  logic               top_branch_q, top_branch_d;
  logic               ovf_q, ovf_d, unf_q, unf_d, eflip_q, eflip_d;
  logic               mem_we;
  logic [IW-1:0]      top_idx, wr_idx;
  logic               is_full, is_empty;

  assign top_idx  = IW'(count_q - CNT_W'(1));
  assign wr_idx   = IW'(count_q);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    br_d         = br_q;
    top_frame_d  = top_frame_q;
    top_branch_d = top_branch_q;
    ovf_d        = ovf_q & ~clr_err_i;
    unf_d        = unf_q & ~clr_err_i;
    eflip_d      = eflip_q & ~clr_err_i;
    mem_we       = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
      count_d = '0;
      br_d    = '0;
    end else if (state_q == S_REFILL) begin
      // count was already decremented on the POP edge, so count-1 is the new top
      state_d      = S_IDLE;
      top_frame_d  = mem_q[top_idx];
      top_branch_d = br_q[top_idx];
    end else if (cmd_valid_i) begin
      case (cmd_op_i)
        OP_NOP: ;
        OP_PUSH: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            mem_we         = 1'b1;
            br_d[wr_idx]   = 1'b0;
            top_frame_d    = push_frame_i;
            top_branch_d   = 1'b0;
            count_d        = count_q + CNT_W'(1);
          end
        end
        OP_POP: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else if (count_q == CNT_W'(1)) begin
            count_d = '0;
          end else begin
            count_d = count_q - CNT_W'(1);
            state_d = S_REFILL;
          end
        end
        OP_FLIP: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else if (top_branch_q) begin
            eflip_d = 1'b1;
          end else begin
            br_d[top_idx] = 1'b1;
            top_branch_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame storage carries no reset; only the occupied region is ever read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx] <= push_frame_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      br_q         <= '0;
      top_frame_q  <= '0;
      top_branch_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      eflip_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      br_q         <= br_d;
      top_frame_q  <= top_frame_d;
      top_branch_q <= top_branch_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      eflip_q      <= eflip_d;
    end
  end

`ifdef DPLL_STACK_HWM_EN
  logic [CNT_W-1:0] max_depth_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_depth_q <= '0;
    end else if (flush_i) begin
      max_depth_q <= '0;
    end else if (count_d > max_depth_q) begin
      max_depth_q <= count_d;
    end
  end

  assign max_depth_o = max_depth_q;
`endif

  assign cmd_ready_o     = (state_q == S_IDLE);
  assign top_valid_o     = !is_empty && (state_q == S_IDLE);
  assign top_frame_o     = top_frame_q;
  assign top_branch_o    = top_branch_q;
  assign count_o         = count_q;
  assign full_o          = is_full;
  assign empty_o         = is_empty;
  assign err_overflow_o  = ovf_q;
  assign err_underflow_o = unf_q;
  assign err_flip_o      = eflip_q;

endmodule

`default_nettype wire

// File: tb/tb_dpll_frame_stack.sv
// ============================================================================
// Module   : tb_dpll_frame_stack
// Brief    : Scoreboard bench for dpll_frame_stack (driver queues expectations,
//            monitor pops and compares after each edge / async reset).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dpll_frame_stack;

  localparam int NC    = 10;
  localparam int NL    = 5;
  localparam int DEPTH = 5;
  localparam int LW    = $clog2(NL + 1);
  localparam int CW    = $clog2(NC + 1);
  localparam int FW    = NC * (NL * (LW + 1) + LW) + CW + 2 * NL;
  localparam int CNTW  = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_FLIP = 2'b11;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            cmd_valid = 1'b0;
  logic [1:0]      cmd_op = 2'b00;
  logic [FW-1:0]   push_frame = '0;
  logic            clr_err = 1'b0;
  logic            cmd_ready, top_valid, top_branch, full, empty;
  logic            err_overflow, err_underflow, err_flip;
  logic [FW-1:0]   top_frame;
  logic [CNTW-1:0] count;
`ifdef DPLL_STACK_HWM_EN
  logic [CNTW-1:0] max_depth;
`endif

  dpll_frame_stack #(.NUM_CLAUSES(NC), .NUM_LITS(NL), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .cmd_valid_i    (cmd_valid),
    .cmd_op_i       (cmd_op),
    .cmd_ready_o    (cmd_ready),
    .push_frame_i   (push_frame),
    .top_valid_o    (top_valid),
    .top_frame_o    (top_frame),
    .top_branch_o   (top_branch),
    .count_o        (count),
    .full_o         (full),
    .empty_o        (empty),
    .clr_err_i      (clr_err),
    .err_overflow_o (err_overflow),
    .err_underflow_o(err_underflow),
    .err_flip_o     (err_flip)
`ifdef DPLL_STACK_HWM_EN
    ,
    .max_depth_o    (max_depth)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rdy, tv, br, ovf, unf, ef, chk_top;
    logic [CNTW-1:0] cnt, mx;
    logic [FW-1:0]   fr;
  } exp_t;

  exp_t e;
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [FW-1:0] mkf(input int k);
    logic [255:0] t;
    t = {8{32'hC0DE_0000 | 32'(k) | (32'(k) << 20)}};
    return t[FW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic set_reset_exp();
    e.rdy = 1'b1; e.tv = 1'b0; e.br = 1'b0; e.ovf = 1'b0; e.unf = 1'b0;
    e.ef = 1'b0; e.chk_top = 1'b1; e.cnt = '0; e.mx = '0; e.fr = '0;
  endtask

  // Drive one cycle of stimulus and queue the state expected after the next edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [FW-1:0] f,
                      input logic fl, input logic clr);
    @(negedge clk);
    cmd_valid = v; cmd_op = op; push_frame = f; flush = fl; clr_err = clr;
    exp_q.push_back(e);
  endtask

  task automatic do_push(input int k);
    if (e.cnt == DEPTH) begin
      e.ovf = 1'b1;
    end else begin
      e.cnt++; e.fr = mkf(k); e.br = 1'b0; e.tv = 1'b1;
      if (e.cnt > e.mx) e.mx = e.cnt;
    end
    e.chk_top = e.tv;
    step(1'b1, OP_PUSH, mkf(k), 1'b0, 1'b0);
  endtask

  task automatic do_flip();
    if (e.cnt == 0) e.unf = 1'b1;
    else if (e.br) e.ef = 1'b1;
    else e.br = 1'b1;
    step(1'b1, OP_FLIP, mkf(0), 1'b0, 1'b0);
  endtask

  // POP with count>1: one REFILL cycle (command v2/op2 offered there must be ignored).
  task automatic pop_refill(input int ncnt, input int k, input logic b,
                            input logic v2, input logic [1:0] op2);
    e.cnt = CNTW'(ncnt); e.rdy = 1'b0; e.tv = 1'b0; e.chk_top = 1'b0;
    step(1'b1, OP_POP, mkf(0), 1'b0, 1'b0);
    e.rdy = 1'b1; e.tv = 1'b1; e.chk_top = 1'b1; e.fr = mkf(k); e.br = b;
    step(v2, op2, mkf(9), 1'b0, 1'b0);
  endtask

  // Monitor: compares after every clock edge and on async reset assertion.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("cmd_ready", 256'(cmd_ready), 256'(x.rdy));
        chk("top_valid", 256'(top_valid), 256'(x.tv));
        chk("count", 256'(count), 256'(x.cnt));
        chk("full", 256'(full), 256'(x.cnt == DEPTH));
        chk("empty", 256'(empty), 256'(x.cnt == 0));
        chk("err_overflow", 256'(err_overflow), 256'(x.ovf));
        chk("err_underflow", 256'(err_underflow), 256'(x.unf));
        chk("err_flip", 256'(err_flip), 256'(x.ef));
`ifdef DPLL_STACK_HWM_EN
        chk("max_depth", 256'(max_depth), 256'(x.mx));
`endif
        if (x.chk_top) begin
          chk("top_frame", 256'(top_frame), 256'(x.fr));
          chk("top_branch", 256'(top_branch), 256'(x.br));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : driver
    set_reset_exp();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, OP_NOP, '0, 1'b0, 1'b0);

    // Fill A..E, then overflow with F
    for (int k = 1; k <= 6; k++) do_push(k);
    do_flip();
    do_flip();
    pop_refill(4, 4, 1'b0, 1'b0, OP_NOP);

    // Branch bit of D survives a push/pop of F
    do_flip();
    do_push(6);
    pop_refill(4, 4, 1'b1, 1'b1, OP_NOP);
    e.ovf = 1'b0; e.ef = 1'b0;
    step(1'b0, OP_NOP, '0, 1'b0, 1'b1);

    // Commands offered during REFILL are ignored
    pop_refill(3, 3, 1'b0, 1'b1, OP_PUSH);
    pop_refill(2, 2, 1'b0, 1'b1, OP_POP);
    pop_refill(1, 1, 1'b0, 1'b0, OP_NOP);

    // Pop to empty (no REFILL), then underflow handling
    e.cnt = '0; e.tv = 1'b0; e.chk_top = 1'b0;
    step(1'b1, OP_POP, '0, 1'b0, 1'b0);
    e.unf = 1'b1;
    step(1'b1, OP_POP, '0, 1'b0, 1'b0);
    e.unf = 1'b0;
    step(1'b0, OP_NOP, '0, 1'b0, 1'b1);
    do_flip();
    step(1'b1, OP_POP, '0, 1'b0, 1'b1);
    e.unf = 1'b0;
    step(1'b0, OP_NOP, '0, 1'b0, 1'b1);

    // Flush with a concurrent PUSH
    for (int k = 1; k <= 3; k++) do_push(k);
    e.cnt = '0; e.tv = 1'b0; e.chk_top = 1'b0; e.mx = '0;
    step(1'b1, OP_PUSH, mkf(4), 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) do_push(k);

    // Async reset in the middle of REFILL
    e.cnt = 2'd2; e.rdy = 1'b0; e.tv = 1'b0; e.chk_top = 1'b0;
    step(1'b1, OP_POP, '0, 1'b0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0; rst_n = 1'b0;
    set_reset_exp();
    exp_q.push_back(e);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(e);
    do_push(5);
    step(1'b0, OP_NOP, '0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
